// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Assembles 4-byte write frames (header, address, data, checksum) from the
// UART receiver handshake and turns each validated frame into one register
// write. Each frame outcome is reported as a cmd_ok or cmd_err pulse.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   rx_data/valid/error  receiver byte, valid and error, held until rx_ack
//   rx_ack             one-cycle acknowledge to the receiver
//   wr_en/addr/data    register write request, completes when wr_ready high
//   wr_ready           register file accepts the write
//   cmd_ok, cmd_err    one-cycle frame outcome pulses
//   err_code           cause of last cmd_err: 00 checksum, 01 address range,
//                      10 timeout, 11 receiver error
//
// state  | meaning
// sHDR   | waiting for header byte, non-header bytes dropped
// sADDR  | waiting for address byte
// sDATA  | waiting for data byte
// sSUM   | waiting for checksum byte (addr XOR data)
// sWRITE | wr_en high until wr_ready, receiver not serviced

module uart_cmd_ctrl #(
   parameter int          C_CLK_FRQ        = 100000000,
   parameter int          C_TIMEOUT_CYCLES = 100000,
   parameter int          C_REG_NUM        = 8,
   parameter logic [7:0]  C_HEADER         = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_error,
   output logic       rx_ack,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic       wr_ready,
   output logic       cmd_ok,
   output logic       cmd_err,
   output logic [1:0] err_code
);

   localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
   // The abort happens on the edge at which the count would reach
   // C_TIMEOUT_CYCLES-1, so the registered count never holds that value.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(C_TIMEOUT_CYCLES - 2);

   if (C_CLK_FRQ <= 0 || C_TIMEOUT_CYCLES < 3) begin : gBadParam
      $error("uart_cmd_ctrl: C_CLK_FRQ must be positive and C_TIMEOUT_CYCLES >= 3");
   end

   typedef enum logic [2:0] {sHDR, sADDR, sDATA, sSUM, sWRITE} stateType;

   stateType         state;
   logic             armed;
   logic [CNT_W-1:0] toCnt;

   logic rxEvent;
   logic accept;
   logic inFrame;
   logic timeoutHit;

   always_comb begin
      rxEvent    = rx_valid | rx_error;
      accept     = armed && rxEvent && (state != sWRITE);
      inFrame    = (state == sADDR) || (state == sDATA) || (state == sSUM);
      timeoutHit = inFrame && (toCnt == TO_LAST) && !accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= sHDR;
         armed    <= 1'b1;
         toCnt    <= '0;
         rx_ack   <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= 8'h00;
         wr_data  <= 8'h00;
         cmd_ok   <= 1'b0;
         cmd_err  <= 1'b0;
         err_code <= 2'b00;
      end else begin
         rx_ack  <= accept;
         cmd_ok  <= 1'b0;
         cmd_err <= 1'b0;

         // Re-arm only once the receiver has dropped valid/error, so a byte
         // still held high during its ack cycle is not consumed twice.
         if (!rxEvent) begin
            armed <= 1'b1;
         end else if (accept) begin
            armed <= 1'b0;
         end

         if (accept || !inFrame || timeoutHit) begin
            toCnt <= '0;
         end else begin
            toCnt <= toCnt + CNT_W'(1);
         end

         if (state == sWRITE) begin
            if (wr_ready) begin
               wr_en  <= 1'b0;
               cmd_ok <= 1'b1;
               state  <= sHDR;
            end
         end else if (accept) begin
            if (rx_error) begin
               cmd_err  <= 1'b1;
               err_code <= 2'b11;
               state    <= sHDR;
            end else begin
               case (state)
                  sHDR: begin
                     if (rx_data == C_HEADER) begin
                        state <= sADDR;
                     end
                  end
                  sADDR: begin
                     wr_addr <= rx_data;
                     state   <= sDATA;
                  end
                  sDATA: begin
                     wr_data <= rx_data;
                     state   <= sSUM;
                  end
                  sSUM: begin
                     if (rx_data != (wr_addr ^ wr_data)) begin
                        cmd_err  <= 1'b1;
                        err_code <= 2'b00;
                        state    <= sHDR;
                     end else if (int'(wr_addr) >= C_REG_NUM) begin
                        cmd_err  <= 1'b1;
                        err_code <= 2'b01;
                        state    <= sHDR;
                     end else begin
                        wr_en <= 1'b1;
                        state <= sWRITE;
                     end
                  end
                  default: state <= sHDR;
               endcase
            end
         end else if (timeoutHit) begin
            cmd_err  <= 1'b1;
            err_code <= 2'b10;
            state    <= sHDR;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

   localparam int T_OUT = 40;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       rx_ack;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       cmd_ok;
   logic       cmd_err;
   logic [1:0] err_code;

   uart_cmd_ctrl #(
      .C_CLK_FRQ       (100000000),
      .C_TIMEOUT_CYCLES(T_OUT),
      .C_REG_NUM       (8),
      .C_HEADER        (8'hA5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_error(rx_error),
      .rx_ack  (rx_ack),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_ready(wr_ready),
      .cmd_ok  (cmd_ok),
      .cmd_err (cmd_err),
      .err_code(err_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Output monitor, sampled on the falling edge.
   int ackCnt = 0, wrCnt = 0, okCnt = 0, errCnt = 0, overlap = 0;
   int lastAckCyc = 0, okCyc = 0, errCyc = 0;
   logic [7:0] capAddr = 8'h00, capData = 8'h00;
   logic [1:0] capCode = 2'b00;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_ack) begin
            ackCnt++;
            lastAckCyc = cyc;
         end
         if (wr_en) begin
            wrCnt++;
            capAddr = wr_addr;
            capData = wr_data;
         end
         if (cmd_ok) begin
            okCnt++;
            okCyc = cyc;
         end
         if (cmd_err) begin
            errCnt++;
            errCyc = cyc;
            capCode = err_code;
         end
         if (cmd_ok && cmd_err) overlap++;
      end
   end

   int nChecks = 0;
   int nErrors = 0;

   task automatic check(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nErrors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sendRaw(input logic [7:0] b, input bit isErr);
      bit got;
      got = 1'b0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = !isErr;
      rx_error = isErr;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (rx_ack) begin
            got = 1'b1;
            break;
         end
      end
      rx_valid = 1'b0;
      rx_error = 1'b0;
      check($sformatf("ack_wait_%02h", b), int'(got), 1);
   endtask

   task automatic sendByte(input logic [7:0] b);
      sendRaw(b, 1'b0);
   endtask

   task automatic sendFrame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
      sendByte(8'hA5);
      sendByte(a);
      sendByte(d);
      sendByte(s);
   endtask

   typedef struct {
      int         n;
      logic [7:0] b [5];
      bit         expOk;
      bit         expErr;
      logic [1:0] expCode;
      logic [7:0] expAddr;
      logic [7:0] expData;
   } vecT;

   vecT vecs [7];

   task automatic setVec(input int i, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4,
                         input bit ok, input bit er, input logic [1:0] code,
                         input logic [7:0] a, input logic [7:0] d);
      vecs[i].n = n;
      vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
      vecs[i].b[3] = b3; vecs[i].b[4] = b4;
      vecs[i].expOk = ok;
      vecs[i].expErr = er;
      vecs[i].expCode = code;
      vecs[i].expAddr = a;
      vecs[i].expData = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int bAck, bWr, bOk, bErr, pendAck;
   bit got;

   initial begin
      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rx_error = 1'b0;
      wr_ready = 1'b1;

      //        n  bytes                              ok er code  addr   data
      setVec(0, 4, 8'hA5, 8'h03, 8'h5C, 8'h5F, 8'h00, 1, 0, 2'b00, 8'h03, 8'h5C);
      setVec(1, 4, 8'hA5, 8'h03, 8'h5C, 8'h00, 8'h00, 0, 1, 2'b00, 8'h00, 8'h00);
      setVec(2, 4, 8'hA5, 8'h09, 8'h11, 8'h18, 8'h00, 0, 1, 2'b01, 8'h00, 8'h00);
      setVec(3, 4, 8'hA5, 8'h07, 8'hFF, 8'hF8, 8'h00, 1, 0, 2'b00, 8'h07, 8'hFF);
      setVec(4, 4, 8'hA5, 8'h08, 8'h00, 8'h08, 8'h00, 0, 1, 2'b01, 8'h00, 8'h00);
      setVec(5, 5, 8'h3C, 8'hA5, 8'h02, 8'h10, 8'h12, 1, 0, 2'b00, 8'h02, 8'h10);
      setVec(6, 4, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 2'b00, 8'h00, 8'h00);

      #12;
      check("rst_rx_ack", int'(rx_ack), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_cmd_ok", int'(cmd_ok), 0);
      check("rst_cmd_err", int'(cmd_err), 0);
      check("rst_err_code", int'(err_code), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Table-driven frames with wr_ready tied high.
      for (int i = 0; i < 7; i++) begin
         bAck = ackCnt; bWr = wrCnt; bOk = okCnt; bErr = errCnt;
         for (int j = 0; j < vecs[i].n; j++) sendByte(vecs[i].b[j]);
         repeat (6) @(negedge clk);
         check($sformatf("v%0d_acks", i), ackCnt - bAck, vecs[i].n);
         check($sformatf("v%0d_ok", i), okCnt - bOk, int'(vecs[i].expOk));
         check($sformatf("v%0d_err", i), errCnt - bErr, int'(vecs[i].expErr));
         check($sformatf("v%0d_wr_cycles", i), wrCnt - bWr, int'(vecs[i].expOk));
         if (vecs[i].expErr) begin
            check($sformatf("v%0d_err_code", i), int'(capCode), int'(vecs[i].expCode));
            check($sformatf("v%0d_err_latency", i), errCyc - lastAckCyc, 0);
         end
         if (vecs[i].expOk) begin
            check($sformatf("v%0d_wr_addr", i), int'(capAddr), int'(vecs[i].expAddr));
            check($sformatf("v%0d_wr_data", i), int'(capData), int'(vecs[i].expData));
            check($sformatf("v%0d_ok_latency", i), okCyc - lastAckCyc, 1);
         end
      end

      // Inter-byte timeout after the address byte.
      bWr = wrCnt; bOk = okCnt; bErr = errCnt;
      sendByte(8'hA5);
      sendByte(8'h01);
      got = 1'b0;
      for (int k = 0; k < T_OUT + 20; k++) begin
         @(negedge clk);
         if (errCnt != bErr) begin
            got = 1'b1;
            break;
         end
      end
      @(negedge clk);
      check("to_seen", int'(got), 1);
      check("to_err_count", errCnt - bErr, 1);
      check("to_err_code", int'(capCode), 2);
      check("to_latency", errCyc - lastAckCyc, T_OUT - 1);
      check("to_no_write", wrCnt - bWr, 0);
      check("to_no_ok", okCnt - bOk, 0);

      // Receiver error in sHDR, then in sDATA, then a good frame.
      bAck = ackCnt; bErr = errCnt;
      sendRaw(8'h00, 1'b1);
      repeat (2) @(negedge clk);
      check("rxerr_hdr_err", errCnt - bErr, 1);
      check("rxerr_hdr_code", int'(capCode), 3);
      bErr = errCnt; bWr = wrCnt;
      sendByte(8'hA5);
      sendByte(8'h03);
      sendRaw(8'h00, 1'b1);
      repeat (2) @(negedge clk);
      check("rxerr_data_err", errCnt - bErr, 1);
      check("rxerr_data_code", int'(capCode), 3);
      check("rxerr_data_latency", errCyc - lastAckCyc, 0);
      check("rxerr_acks", ackCnt - bAck, 4);
      check("rxerr_no_write", wrCnt - bWr, 0);
      bOk = okCnt;
      sendFrame(8'h03, 8'h5C, 8'h5F);
      repeat (4) @(negedge clk);
      check("rxerr_recover_ok", okCnt - bOk, 1);

      // wr_ready held low with a fifth byte pending.
      bAck = ackCnt; bWr = wrCnt; bOk = okCnt;
      wr_ready = 1'b0;
      sendFrame(8'h03, 8'h5C, 8'h5F);
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      repeat (19) @(negedge clk);
      wr_ready = 1'b1;
      got = 1'b0;
      pendAck = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rx_ack) begin
            got = 1'b1;
            pendAck = cyc;
            break;
         end
      end
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_pend_acked", int'(got), 1);
      check("hold_wr_cycles", wrCnt - bWr, 21);
      check("hold_ok", okCnt - bOk, 1);
      check("hold_pend_after_ok", pendAck - okCyc, 1);
      check("hold_acks", ackCnt - bAck, 5);

      // Asynchronous reset during an outstanding write (also clears the
      // header left over from the previous step).
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wr_ready = 1'b0;
      sendFrame(8'h05, 8'h22, 8'h27);
      check("arst_wr_en_before", int'(wr_en), 1);
      #1 rst = 1'b1;
      #1;
      check("arst_wr_en", int'(wr_en), 0);
      check("arst_wr_addr", int'(wr_addr), 0);
      check("arst_wr_data", int'(wr_data), 0);
      check("arst_rx_ack", int'(rx_ack), 0);
      check("arst_cmd_ok", int'(cmd_ok), 0);
      #1 rst = 1'b0;
      bWr = wrCnt; bOk = okCnt;
      wr_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_write_after", wrCnt - bWr, 0);
      check("arst_no_ok_after", okCnt - bOk, 0);
      sendFrame(8'h06, 8'h81, 8'h87);
      repeat (4) @(negedge clk);
      check("arst_recover_ok", okCnt - bOk, 1);
      check("arst_recover_addr", int'(capAddr), 8'h06);
      check("arst_recover_data", int'(capData), 8'h81);

      check("ok_err_overlap", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
